br32_ctrl: RTL and testbench
============================

# br32_ctrl

Evaluation sequencer for the 32-bit bistable ring PUF macro (BR32). It accepts a challenge over a valid/ready request channel and drives the ring's challenge and reset pins. It holds the ring in reset, releases it for a fixed settle window, then samples the asynchronous ring output through a synchronizer. The response bit is returned over a valid/ready channel; optionally it is the majority of repeated evaluations of the same challenge.

## Interface
- RST_CYC, 4: cycles RING_RESET is held high per evaluation (≥1)
- SETTLE_CYC, 64: cycles the ring runs free before sampling (≥3)
- NVOTE, 7: evaluations per request when voting is compiled in (odd, ≥1)
- CW, 32: challenge width; fixed to the macro width
- VW, $clog2(NVOTE+1): width of the ones count

- CLK  in  1  sole clock
- RST_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  challenge request valid
- REQ_READY  out  1  controller idle, can accept
- REQ_C  in  CW  challenge
- RSP_VALID  out  1  response valid, held until accepted
- RSP_READY  in  1  consumer accepts response
- RSP_BIT  out  1  response bit
- RSP_ONES  out  VW  number of evaluations that sampled 1
- RING_RESET  out  1  to BR32 RESET, active-high ring reset
- RING_C  out  CW  to BR32 C
- RING_OUT  in  1  from BR32 OUT, asynchronous

## Operation
- States: IDLE, RST, SETTLE, DONE.
- IDLE: REQ_READY=1, RING_RESET=1 (ring parked), RING_C holds its last value.
- The request is accepted when REQ_VALID&&REQ_READY at a rising edge. On that edge:
  - RING_C<=REQ_C
  - eval counter<=0
  - ones<=0
  - state->RST
- RST: RING_RESET=1 for RST_CYC cycles, then state->SETTLE.
- SETTLE: RING_RESET=0 for SETTLE_CYC cycles. On the last edge, the synchronized RING_OUT is added to ones and the eval counter increments.
  - If evaluations done < NVOTE (voting builds): state->RST.
  - Otherwise: state->DONE.
- DONE: RSP_VALID=1, RING_RESET=1, RSP_BIT=(ones > NVOTE/2), RSP_ONES=ones. On RSP_VALID&&RSP_READY: state->IDLE.
- RING_OUT passes through a 2-flop synchronizer that runs continuously. SETTLE_CYC≥3 guarantees the sampled value was launched after reset release.
- REQ_C is ignored outside IDLE. RING_C never changes while RING_RESET=0.

## Timing
- Reset values:
  - state=IDLE, REQ_READY=1, RSP_VALID=0
  - RSP_BIT=0, RSP_ONES=0
  - RING_RESET=1, RING_C=0
  - sync flops=0
- Latency: RSP_VALID rises exactly N·(RST_CYC+SETTLE_CYC) cycles after the accepting edge. N=NVOTE with voting, N=1 without. Defaults: 68 cycles (single) or 476 cycles (vote).
- RSP_BIT and RSP_ONES are stable while RSP_VALID=1, regardless of RSP_READY.
- RSP_READY high on the same edge RSP_VALID rises counts as the handshake; state->IDLE next cycle.
- No back-to-back overlap: REQ_READY=0 in DONE. The earliest next acceptance is the cycle after the response handshake.
- RING_RESET is registered and glitch-free. Every high→low transition is preceded by ≥RST_CYC high cycles with a stable RING_C.
- Async reset mid-evaluation: immediately RING_RESET=1, RSP_VALID=0, state=IDLE. The partial vote is discarded.
- ones saturation is impossible, since VW covers NVOTE.

## Configuration
- BR32_CTRL_VOTE_EN defined: NVOTE evaluations per request, majority output, RSP_ONES is the true count.
- Undefined: exactly one evaluation, NVOTE ignored, RSP_BIT is the single sample, RSP_ONES={VW-1 zeros, RSP_BIT}.
- Port list is identical in both builds.

## Structure
- Package br32_ctrl_pkg holds:
  - state enum
  - BR32_CW=32 constant
  - default RST_CYC/SETTLE_CYC/NVOTE constants
- Sub-module br32_sync: 2-flop synchronizer on RING_OUT with async active-low reset to 0.
- FSM, phase counter (width $clog2(max(RST_CYC,SETTLE_CYC))), eval counter and ones accumulator live in br32_ctrl.

## Test plan
- Reset, then idle 10 cycles → REQ_READY=1, RING_RESET=1, RING_C=0, RSP_VALID=0.
- Single build, REQ_C=32'hDEADBEEF, RING_OUT model returns 1 after release → RING_C=DEADBEEF from the accept edge. RING_RESET low for exactly 64 cycles. RSP_VALID at accept+68, RSP_BIT=1, RSP_ONES=1.
- Vote build, ring model returns 1,0,1,1,0,0,1 → 7 reset pulses of 4 cycles. RSP_ONES=4, RSP_BIT=1 at accept+476.
- Vote build, pattern 0,0,1,0,1,0,0 → RSP_ONES=2, RSP_BIT=0.
- Hold RSP_READY=0 for 20 cycles with REQ_VALID=1 and a new REQ_C → RSP fields stable, REQ_READY=0, RING_C unchanged. Raise RSP_READY → new challenge accepted the following cycle.
- Assert RST_N low during SETTLE → RING_RESET=1 in the same cycle, RSP_VALID never pulses, a fresh request after release completes normally.

Source files
------------

// File: rtl/br32_ctrl_pkg.sv
// br32_ctrl_pkg: shared state encoding and default timing constants for the
// BR32 bistable-ring PUF evaluation sequencer.
package br32_ctrl_pkg;

    localparam int BR32_CW        = 32;
    localparam int DEF_RST_CYC    = 4;
    localparam int DEF_SETTLE_CYC = 64;
    localparam int DEF_NVOTE      = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RST    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/br32_sync.sv
// br32_sync: two-flop synchronizer bringing the asynchronous ring output into
// the controller clock domain. Runs continuously and clears to 0 on reset.
module br32_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw ring output through two flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/br32_ctrl.sv
// br32_ctrl: evaluation sequencer for the BR32 bistable-ring PUF macro.
// Accepts a challenge, parks the ring in reset, releases it for a fixed settle
// window and samples the synchronized ring output. With BR32_CTRL_VOTE_EN
// defined the challenge is evaluated NVOTE times and the majority is returned;
// otherwise a single evaluation is performed.
module br32_ctrl
    import br32_ctrl_pkg::*;
#(
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int NVOTE      = DEF_NVOTE,
    parameter int CW         = BR32_CW,
    parameter int VW         = $clog2(NVOTE + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [CW-1:0] req_c,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_bit,
    output logic [VW-1:0] rsp_ones,
    output logic          ring_reset,
    output logic [CW-1:0] ring_c,
    input  logic          ring_out
);

`ifdef BR32_CTRL_VOTE_EN
    localparam int NEVAL = NVOTE;
`else
    localparam int NEVAL = 1;
`endif

    localparam int            PW          = $clog2(max_int(RST_CYC, SETTLE_CYC));
    localparam logic [PW-1:0] RST_LAST    = PW'(RST_CYC - 1);
    localparam logic [PW-1:0] SETTLE_LAST = PW'(SETTLE_CYC - 1);
    localparam logic [VW-1:0] EVAL_LAST   = VW'(NEVAL - 1);
    localparam logic [VW-1:0] MAJ_HALF    = VW'(NEVAL / 2);

    state_t        state;
    logic [PW-1:0] phase;
    logic [VW-1:0] eval_cnt;
    logic [VW-1:0] ones;
    logic [VW-1:0] ones_next;
    logic          ring_sync;

    br32_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ring_out),
        .q     (ring_sync)
    );

    assign ones_next = ones + VW'(ring_sync);

    // Sequencer: accept a challenge, alternate reset/settle windows per
    // evaluation, then hold the response until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase      <= '0;
            eval_cnt   <= '0;
            ones       <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_bit    <= 1'b0;
            rsp_ones   <= '0;
            ring_reset <= 1'b1;
            ring_c     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        ring_c    <= req_c;
                        eval_cnt  <= '0;
                        ones      <= '0;
                        phase     <= '0;
                        req_ready <= 1'b0;
                        state     <= ST_RST;
                    end
                end
                ST_RST: begin
                    if (phase == RST_LAST) begin
                        phase      <= '0;
                        ring_reset <= 1'b0;
                        state      <= ST_SETTLE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (phase == SETTLE_LAST) begin
                        phase      <= '0;
                        ring_reset <= 1'b1;
                        ones       <= ones_next;
                        eval_cnt   <= eval_cnt + VW'(1);
                        if (eval_cnt == EVAL_LAST) begin
                            rsp_valid <= 1'b1;
                            rsp_bit   <= (ones_next > MAJ_HALF);
                            rsp_ones  <= ones_next;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_RST;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_br32_ctrl.sv
// tb_br32_ctrl: randomized scoreboard bench for br32_ctrl. Works in both the
// single-evaluation build and the BR32_CTRL_VOTE_EN build.
module tb_br32_ctrl;
    import br32_ctrl_pkg::*;

    localparam int RST_CYC    = DEF_RST_CYC;
    localparam int SETTLE_CYC = DEF_SETTLE_CYC;
    localparam int VW         = $clog2(DEF_NVOTE + 1);
`ifdef BR32_CTRL_VOTE_EN
    localparam int NEVAL = DEF_NVOTE;
`else
    localparam int NEVAL = 1;
`endif
    localparam int LAT     = NEVAL * (RST_CYC + SETTLE_CYC);
    localparam int TIMEOUT = LAT + 200;

    typedef struct {
        logic          exp_bit;
        logic [VW-1:0] exp_ones;
        int            acc_cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_c;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_bit;
    logic [VW-1:0] rsp_ones;
    logic          ring_reset;
    logic [31:0]   ring_c;
    logic          ring_out;

    exp_t sb[$];
    logic ring_bits[$];

    int cyc     = 0;
    int checks  = 0;
    int errors  = 0;
    int hs_cyc  = 0;
    int last_acc = 0;
    int rsp_mode = 2;

    br32_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_c      (req_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_bit    (rsp_bit),
        .rsp_ones   (rsp_ones),
        .ring_reset (ring_reset),
        .ring_c     (ring_c),
        .ring_out   (ring_out)
    );

    // Free-running clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response consumer: random, forced-low or forced-high ready, changed just after each edge.
    always @(posedge clk) begin
        #1;
        case (rsp_mode)
            1:       rsp_ready = 1'b0;
            2:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Ring model: after each reset release the ring settles to the next queued bit.
    logic drv_prev_rr = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            drv_prev_rr = 1'b1;
        end else begin
            if (!ring_reset && drv_prev_rr) begin
                if (ring_bits.size() > 0) ring_out = ring_bits.pop_front();
                else                      ring_out = 1'($urandom_range(0, 1));
            end else if (ring_reset) begin
                ring_out = 1'($urandom_range(0, 1));
            end
            drv_prev_rr = ring_reset;
        end
    end

    // Ring pin monitor: settle window length, reset hold before release, challenge stability.
    int         low_cnt   = 0;
    int         stable_hi = 0;
    logic       mon_prev_rr = 1'b1;
    logic [31:0] prev_c   = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            low_cnt     = 0;
            stable_hi   = 0;
            mon_prev_rr = 1'b1;
            prev_c      = ring_c;
        end else begin
            if (ring_reset) begin
                if (!mon_prev_rr) check_output("settle_len", 64'(low_cnt), 64'(SETTLE_CYC));
                if (ring_c == prev_c) stable_hi++;
                else                  stable_hi = 1;
                low_cnt = 0;
            end else begin
                if (mon_prev_rr) check_output("reset_hold", 64'(stable_hi >= RST_CYC), 64'(1));
                else             check_output("ring_c_stable", 64'(ring_c), 64'(prev_c));
                low_cnt++;
                stable_hi = 0;
            end
            mon_prev_rr = ring_reset;
            prev_c      = ring_c;
        end
    end

    // Response monitor: pops the scoreboard when a response appears and checks hold/handshake rules.
    logic          prev_valid = 1'b0;
    logic          exp_drop   = 1'b0;
    logic          held_bit;
    logic [VW-1:0] held_ones;
    exp_t          cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            exp_drop   = 1'b0;
        end else begin
            if (exp_drop) begin
                check_output("rsp_drop_after_hs", 64'(rsp_valid), 64'(0));
                check_output("ready_after_hs", 64'(req_ready), 64'(1));
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check_output("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    cur = sb.pop_front();
                    check_output("rsp_bit", 64'(rsp_bit), 64'(cur.exp_bit));
                    check_output("rsp_ones", 64'(rsp_ones), 64'(cur.exp_ones));
                    check_output("latency", 64'(cyc - cur.acc_cyc), 64'(LAT));
                end
                held_bit  = rsp_bit;
                held_ones = rsp_ones;
            end else if (rsp_valid && prev_valid) begin
                check_output("rsp_bit_hold", 64'(rsp_bit), 64'(held_bit));
                check_output("rsp_ones_hold", 64'(rsp_ones), 64'(held_ones));
            end
            if (rsp_valid) check_output("req_ready_in_done", 64'(req_ready), 64'(0));
            exp_drop = rsp_valid && rsp_ready;
            if (exp_drop) hs_cyc = cyc + 1;
            prev_valid = rsp_valid;
        end
    end

    // Issue one challenge; the ring will answer evaluation i with pat[i].
    task automatic apply_stimulus(input logic [31:0] c, input logic [6:0] pat);
        exp_t e;
        int   n1;
        int   waited;
        @(negedge clk);
        req_valid = 1'b1;
        req_c     = c;
        waited    = 0;
        while (!req_ready && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check_output("accept_timeout", 64'(req_ready), 64'(1));
            req_valid = 1'b0;
            return;
        end
        n1 = 0;
        for (int i = 0; i < NEVAL; i++) begin
            ring_bits.push_back(pat[i]);
            n1 += int'(pat[i]);
        end
        e.exp_ones = VW'(n1);
        e.exp_bit  = (2 * n1 > NEVAL);
        e.acc_cyc  = cyc + 1;
        sb.push_back(e);
        last_acc = e.acc_cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_c     = $urandom();
        check_output("ring_c_loaded", 64'(ring_c), 64'(c));
        check_output("ready_drop", 64'(req_ready), 64'(0));
        check_output("ring_reset_after_acc", 64'(ring_reset), 64'(1));
    endtask

    // Wait until every issued challenge has been answered and the controller is idle.
    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || !req_ready) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check_output("rsp_pending", 64'(sb.size()), 64'(0));
        check_output("idle_after_rsp", 64'(req_ready), 64'(1));
    endtask

    // Main sequence.
    initial begin
        int   n;
        logic [31:0] ca;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_c     = '0;
        ring_out  = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'(1));
        check_output("rst_ring_reset", 64'(ring_reset), 64'(1));
        check_output("rst_ring_c", 64'(ring_c), 64'(0));
        check_output("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_output("rst_rsp_bit", 64'(rsp_bit), 64'(0));
        check_output("rst_rsp_ones", 64'(rsp_ones), 64'(0));

        rsp_mode = 2;
        apply_stimulus(32'hDEADBEEF, 7'b1001101);
        wait_done();
        apply_stimulus(32'h12345678, 7'b0010100);
        wait_done();

        rsp_mode = 1;
        ca = $urandom();
        apply_stimulus(ca, 7'($urandom_range(0, 127)));
        n = 0;
        while (!rsp_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check_output("hold_rsp_seen", 64'(rsp_valid), 64'(1));
        req_valid = 1'b1;
        req_c     = ~ca;
        repeat (20) begin
            @(negedge clk);
            check_output("hold_req_ready", 64'(req_ready), 64'(0));
            check_output("hold_ring_c", 64'(ring_c), 64'(ca));
            check_output("hold_rsp_valid", 64'(rsp_valid), 64'(1));
        end
        rsp_mode = 2;
        apply_stimulus(~ca, 7'($urandom_range(0, 127)));
        check_output("accept_after_hs", 64'(last_acc), 64'(hs_cyc + 1));
        wait_done();

        rsp_mode = 0;
        for (int t = 0; t < 5; t++) begin
            apply_stimulus($urandom(), 7'($urandom_range(0, 127)));
            wait_done();
        end

        apply_stimulus($urandom(), 7'($urandom_range(0, 127)));
        n = 0;
        while (ring_reset && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("settle_entered", 64'(ring_reset), 64'(0));
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("arst_ring_reset", 64'(ring_reset), 64'(1));
        check_output("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_output("arst_req_ready", 64'(req_ready), 64'(1));
        sb.delete();
        ring_bits.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 20) @(negedge clk);
        check_output("no_rsp_after_arst", 64'(rsp_valid), 64'(0));
        apply_stimulus($urandom(), 7'($urandom_range(0, 127)));
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
